// File: rtl/sm3_compress_engine_pkg.sv
// -----------------------------------------------------------------------------
// sm3_compress_engine_pkg
// Shared SM3 definitions for the hash blocks: standard IV, round constants,
// FSM state type and the bit-level helper functions (rotate, P0, P1, FF, GG).
// No ports.
// -----------------------------------------------------------------------------
package sm3_compress_engine_pkg;

    localparam logic [255:0] SM3_IV =
        256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

    localparam logic [31:0] T_LO = 32'h79cc4519;  // rounds 0..15
    localparam logic [31:0] T_HI = 32'h7a879d8a;  // rounds 16..63

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN,
        ST_DONE
    } state_t;

    // Rotate left by 0..31; the doubled word makes n=0 fall out naturally.
    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction

    function automatic logic [31:0] p0(input logic [31:0] x);
        return x ^ rol32(x, 5'd9) ^ rol32(x, 5'd17);
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rol32(x, 5'd15) ^ rol32(x, 5'd23);
    endfunction

    // hi selects the round 16..63 form of the boolean functions.
    function automatic logic [31:0] ff(input logic hi, input logic [31:0] x,
                                       input logic [31:0] y, input logic [31:0] z);
        return hi ? ((x & y) | (x & z) | (y & z)) : (x ^ y ^ z);
    endfunction

    function automatic logic [31:0] gg(input logic hi, input logic [31:0] x,
                                       input logic [31:0] y, input logic [31:0] z);
        return hi ? ((x & y) | (~x & z)) : (x ^ y ^ z);
    endfunction

endpackage

// File: rtl/sm3_compress_engine_round.sv
// -----------------------------------------------------------------------------
// sm3_round
// One combinational SM3 compression round plus next message-word generation.
// Ports:
//   j          in  6    round index (0..63)
//   state_in   in  256  working registers {A,B,C,D,E,F,G,H}
//   win_in     in  512  message window W[j..j+15], W[j] in [511:480]
//   state_out  out 256  working registers after round j
//   win_out    out 512  window W[j+1..j+16]
// -----------------------------------------------------------------------------
module sm3_round
    import sm3_compress_engine_pkg::*;
(
    input  logic [5:0]   j,
    input  logic [255:0] state_in,
    input  logic [511:0] win_in,
    output logic [255:0] state_out,
    output logic [511:0] win_out
);

    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] w0, w3, w4, w7, w10, w13, w_next;
    logic [31:0] tj, a12, ss1, ss2, tt1, tt2;
    logic        hi;

    always_comb begin
        {a, b, c, d, e, f, g, h} = state_in;

        w0  = win_in[511:480];
        w3  = win_in[415:384];
        w4  = win_in[383:352];
        w7  = win_in[287:256];
        w10 = win_in[191:160];
        w13 = win_in[95:64];

        hi  = (j >= 6'd16);
        tj  = hi ? T_HI : T_LO;
        a12 = rol32(a, 5'd12);
        ss1 = rol32(a12 + e + rol32(tj, j[4:0]), 5'd7);
        ss2 = ss1 ^ a12;
        tt1 = ff(hi, a, b, c) + d + ss2 + (w0 ^ w4);
        tt2 = gg(hi, e, f, g) + h + ss1 + w0;

        state_out = {tt1, a, rol32(b, 5'd9), c, p0(tt2), e, rol32(f, 5'd19), g};

        // Window slides by one word; W[j+16] enters at the low end.
        w_next  = p1(w0 ^ w7 ^ rol32(w13, 5'd15)) ^ rol32(w3, 5'd7) ^ w10;
        win_out = {win_in[479:0], w_next};
    end

endmodule

// File: rtl/sm3_compress_engine.sv
// -----------------------------------------------------------------------------
// sm3_compress_engine
// SM3 compression function responder: V(i+1) = CF(V(i), B(i)), UNROLL rounds
// per clock, start/done level handshake.
// Parameters:
//   UNROLL    rounds per clock (1, 2 or 4)
// Ports:
//   clk       in   1    clock, rising edge
//   reset     in   1    asynchronous, active-low reset
//   start     in   1    level request, held by initiator until done seen
//   iv        in   256  chaining value, [255:224]=A ... [31:0]=H
//   block     in   512  message block, [511:480]=W0 ... [31:0]=W15
//   hash_out  out  256  V xor final ABCDEFGH, valid while done=1
//   done      out  1    result valid (level)
//   busy      out  1    high while rounds run / result is finalised
// -----------------------------------------------------------------------------
module sm3_compress_engine
    import sm3_compress_engine_pkg::*;
#(
    parameter int unsigned UNROLL = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [255:0] iv,
    input  logic [511:0] block,
    output logic [255:0] hash_out,
    output logic         done,
    output logic         busy
);

    localparam logic [5:0] ROUND_STEP = 6'(UNROLL);
    localparam logic [5:0] ROUND_LAST = 6'(64 - UNROLL);

    state_t       state;
    logic [5:0]   round;
    logic [255:0] v;
    logic [255:0] work;
    logic [511:0] win;

    logic [255:0] st_chain  [UNROLL+1];
    logic [511:0] win_chain [UNROLL+1];

    assign st_chain[0]  = work;
    assign win_chain[0] = win;

    for (genvar i = 0; i < UNROLL; i++) begin : g_round
        localparam logic [5:0] OFS = 6'(i);
        sm3_round u_round (
            .j         (round + OFS),
            .state_in  (st_chain[i]),
            .win_in    (win_chain[i]),
            .state_out (st_chain[i+1]),
            .win_out   (win_chain[i+1])
        );
    end

    // The load step is merged into the IDLE edge that accepts start, so the
    // first round runs on the very next edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            round    <= '0;
            v        <= '0;
            work     <= '0;
            win      <= '0;
            hash_out <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        v     <= iv;
                        work  <= iv;
                        win   <= block;
                        round <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    work  <= st_chain[UNROLL];
                    win   <= win_chain[UNROLL];
                    round <= round + ROUND_STEP;
                    if (round == ROUND_LAST) begin
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    hash_out <= v ^ work;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= ST_DONE;
                end
                ST_DONE: begin
                    // A held start never restarts; it must drop first.
                    if (!start) begin
                        done  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
